// File: rtl/vend_ctrl.sv
// Newspaper vending controller: 15c price, 5c/10c coins, one-clock vend pulse with 5c change code.
// Credit and outputs are held in flops; nothing combinational reaches the outputs from coin.
module vend_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin,
  output logic       newspaper,
  output logic [1:0] res
);

  localparam int unsigned COIN_W = 2;
  localparam int unsigned RES_W  = 2;

  localparam logic [COIN_W-1:0] COIN_5  = COIN_W'(1);
  localparam logic [COIN_W-1:0] COIN_10 = COIN_W'(2);

  localparam logic [RES_W-1:0] RES_NONE = RES_W'(0);
  localparam logic [RES_W-1:0] RES_5C   = RES_W'(1);

  // S_BAD is the unused encoding; it only exists so the recovery path is explicit.
  typedef enum logic [1:0] {
    S0    = 2'd0,
    S5    = 2'd1,
    S10   = 2'd2,
    S_BAD = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             newspaper_nx;
  logic [RES_W-1:0] res_nx;

  // State and output registers; reset discards credit without any refund.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S0;
      newspaper <= 1'b0;
      res       <= RES_NONE;
    end else begin
      state     <= state_nx;
      newspaper <= newspaper_nx;
      res       <= res_nx;
    end
  end

  // Next credit and vend decision; coin codes 0 and 3 hold state with no output.
  always_comb begin
    state_nx     = state;
    newspaper_nx = 1'b0;
    res_nx       = RES_NONE;
    unique case (state)
      S0: begin
        if (coin == COIN_5) begin
          state_nx = S5;
        end else if (coin == COIN_10) begin
          state_nx = S10;
        end
      end
      S5: begin
        if (coin == COIN_5) begin
          state_nx = S10;
        end else if (coin == COIN_10) begin
          state_nx     = S0;
          newspaper_nx = 1'b1;
        end
      end
      S10: begin
        if (coin == COIN_5) begin
          state_nx     = S0;
          newspaper_nx = 1'b1;
        end else if (coin == COIN_10) begin
          state_nx     = S0;
          newspaper_nx = 1'b1;
          res_nx       = RES_5C;
        end
      end
      default: begin
        state_nx = S0;
      end
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: stimulus pushes hand-computed expected outputs,
// a monitor pops and compares one entry per sampling point.
module tb_vend_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] coin;
  logic       newspaper;
  logic [1:0] res;

  typedef struct {
    logic       np;
    logic [1:0] rs;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  vend_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .coin      (coin),
    .newspaper (newspaper),
    .res       (res)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog: the run must finish within a bounded time.
  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Monitor: outputs sampled 1ns after each rising edge or asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (newspaper !== e.np || res !== e.rs) begin
          n_err++;
          $display("FAIL %s: got newspaper=%0b res=%0d, required newspaper=%0b res=%0d",
                   e.name, newspaper, res, e.np, e.rs);
        end
      end
    end
  end

  task automatic push_exp(input logic np, input logic [1:0] rs, input string name);
    exp_t e;
    e.np   = np;
    e.rs   = rs;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Present one coin code for one clock; expectation is the output after that edge.
  task automatic cyc(input logic [1:0] c, input logic np, input logic [1:0] rs, input string name);
    @(negedge clock);
    coin = c;
    push_exp(np, rs, name);
  endtask

  // Pulse reset between edges, hold it across one edge, release on a falling edge.
  task automatic areset(input string name);
    @(posedge clock);
    #3;
    coin = 2'd0;
    push_exp(1'b0, 2'd0, {name, "_immediate"});
    reset = 1'b0;
    @(negedge clock);
    push_exp(1'b0, 2'd0, {name, "_hold"});
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    coin  = 2'd0;
    cyc(2'd0, 1'b0, 2'd0, "reset_state");
    #2;
    n_cmp++;
    if (newspaper !== 1'b0 || res !== 2'd0) begin
      n_err++;
      $display("FAIL reset_direct: got newspaper=%0b res=%0d, required newspaper=0 res=0",
               newspaper, res);
    end
    @(negedge clock);
    reset = 1'b1;

    // Three nickels with idle gaps
    cyc(2'd1, 1'b0, 2'd0, "n1_s5");
    cyc(2'd0, 1'b0, 2'd0, "n1_idle");
    cyc(2'd1, 1'b0, 2'd0, "n2_s10");
    cyc(2'd0, 1'b0, 2'd0, "n2_idle");
    cyc(2'd1, 1'b1, 2'd0, "n3_vend");
    cyc(2'd0, 1'b0, 2'd0, "n3_pulse_end");

    // 5c then 10c, and 10c then 5c
    cyc(2'd1, 1'b0, 2'd0, "5_10_first");
    cyc(2'd2, 1'b1, 2'd0, "5_10_vend");
    cyc(2'd0, 1'b0, 2'd0, "5_10_end");
    cyc(2'd2, 1'b0, 2'd0, "10_5_first");
    cyc(2'd1, 1'b1, 2'd0, "10_5_vend");
    cyc(2'd0, 1'b0, 2'd0, "10_5_end");

    // 10c + 10c gives change; following nickel lands in S5 (proved by finishing the sale)
    cyc(2'd2, 1'b0, 2'd0, "10_10_first");
    cyc(2'd2, 1'b1, 2'd1, "10_10_vend_change");
    cyc(2'd0, 1'b0, 2'd0, "10_10_end");
    cyc(2'd1, 1'b0, 2'd0, "after_change_s5");
    cyc(2'd1, 1'b0, 2'd0, "after_change_s10");
    cyc(2'd1, 1'b1, 2'd0, "after_change_vend");
    cyc(2'd0, 1'b0, 2'd0, "after_change_end");

    // Reset with 10c credit: credit must be discarded
    cyc(2'd2, 1'b0, 2'd0, "pre_reset_s10");
    areset("rst_s10");
    cyc(2'd1, 1'b0, 2'd0, "post_reset_5_no_vend");
    cyc(2'd2, 1'b1, 2'd0, "post_reset_vend");
    cyc(2'd0, 1'b0, 2'd0, "post_reset_end");

    // Reset during a vend pulse drops the outputs immediately
    cyc(2'd2, 1'b0, 2'd0, "pulse_rst_first");
    cyc(2'd2, 1'b1, 2'd1, "pulse_rst_vend");
    areset("rst_pulse");
    cyc(2'd1, 1'b0, 2'd0, "pulse_rst_after_s5");
    cyc(2'd0, 1'b0, 2'd0, "pulse_rst_idle");

    // Reset pulse above left S5; finish that sale to return to S0
    cyc(2'd2, 1'b1, 2'd0, "pulse_rst_cleanup_vend");

    // Invalid coin code in S0, S5, S10
    cyc(2'd3, 1'b0, 2'd0, "inv_s0");
    cyc(2'd1, 1'b0, 2'd0, "inv_to_s5");
    cyc(2'd3, 1'b0, 2'd0, "inv_s5");
    cyc(2'd1, 1'b0, 2'd0, "inv_to_s10");
    cyc(2'd3, 1'b0, 2'd0, "inv_s10");
    cyc(2'd1, 1'b1, 2'd0, "inv_vend");
    cyc(2'd0, 1'b0, 2'd0, "inv_end");

    // Back-to-back sales on consecutive edges
    cyc(2'd2, 1'b0, 2'd0, "b2b_c1");
    cyc(2'd2, 1'b1, 2'd1, "b2b_c2_vend_change");
    cyc(2'd2, 1'b0, 2'd0, "b2b_c3_gap");
    cyc(2'd1, 1'b1, 2'd0, "b2b_c4_vend");
    cyc(2'd0, 1'b0, 2'd0, "b2b_end");
    cyc(2'd0, 1'b0, 2'd0, "b2b_idle");

    @(posedge clock);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL expired_wait: %0d expectations never sampled", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Controller for a newspaper vending machine.
- Price is 15 cents. Accepts 5-cent and 10-cent coins, dispenses one newspaper, and returns 5 cents change on overpayment.
- Sits between a coin-sensor front end (already decoded to a 2-bit code, one clock per coin) and the dispense/change actuators.

Parameters:
none (price, coin values and encodings are fixed)

Ports:
clock      input   1  system clock; all state updates on rising edge
reset      input   1  asynchronous, active-low reset
coin       input   2  coin code sampled each rising edge: 0 none, 1 = 5c, 2 = 10c, 3 = invalid
newspaper  output  1  registered; high for exactly one clock when a sale completes
res        output  2  registered change code, valid while newspaper=1: 0 no change, 1 = 5c; otherwise 0

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset=0), at any time including mid-transaction:
  - credit state forced to S0 immediately, independent of clock;
  - newspaper=0, res=0;
  - accumulated credit is discarded, with no refund output.
- Coin sampling:
  - coin is level-sampled on every rising edge while reset=1;
  - each rising edge with coin=1 or 2 counts as one coin;
  - the front end holds a coin code for exactly one clock, then returns it to 0;
  - coin=0 and coin=3 leave state unchanged;
  - coin=3 never vends and never produces change.
- Credit states: S0 (0c), S5 (5c), S10 (10c). There is no 15c-or-above resting state; the sale completes in the same edge.
- Transitions on a rising edge (next state / newspaper / res):
  - S0: 5c -> S5 / 0 / 0; 10c -> S10 / 0 / 0
  - S5: 5c -> S10 / 0 / 0; 10c -> S0 / 1 / 0
  - S10: 5c -> S0 / 1 / 0; 10c -> S0 / 1 / 1
  - any state, coin 0 or 3 -> same state / 0 / 0
- Output timing:
  - newspaper and res are registered and update on the same rising edge as the state;
  - they go high on the edge that samples the completing coin and return to 0 on the next edge, unless that next edge completes another sale;
  - back-to-back completing coins on consecutive edges each produce their own one-cycle pulse.
- Idle cycles (coin=0) between coins preserve credit indefinitely; there is no timeout.
- res is 0 whenever newspaper=0. Encodings 2 and 3 are never driven.
- Registers:
  - state: 2-bit encoded; the unused encoding recovers to S0 on the next edge with newspaper=0 and res=0;
  - one flop for newspaper, two flops for res.
- No combinational path from coin to the outputs.

Test Plan:
- Reset then three 5c coins, one clock each with idle gaps: newspaper=0, res=0 after the 1st and 2nd; after the 3rd, newspaper=1 and res=0 for one clock; then state S0.
- 5c then 10c: newspaper=1, res=0 for one clock after the 10c edge. 10c then 5c gives the same result.
- 10c then 10c: newspaper=1, res=1 for one clock after the 2nd coin, then both return to 0. A following 5c leaves newspaper=0 (state S5).
- 10c, then reset pulsed low asynchronously between clock edges:
  - outputs read 0 immediately;
  - after release, a single 5c gives no vend, so credit was cleared;
  - 5c+10c then vends with res=0.
- coin=3 held for one clock in each of S0, S5 and S10: no state change and no output. Verify by completing the sale with the expected remaining coins.
- Consecutive sales: 10c, 10c, 10c, 5c on consecutive edges:
  - pulse with res=1 after the 2nd coin;
  - pulse with res=0 after the 4th coin;
  - newspaper low between the pulses.
